// File: rtl/raster_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module      : raster_pixel_sink
// Description : Write-side endpoint between the rasterizer pixel port and the
//               double-buffered frame memory. Buffers pixel strobes in a small
//               FIFO, converts (x, y) to a linear offset, writes into the back
//               bank and swaps banks on the clipping unit's frame-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_pixel_sink #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rast_pixel_rdy,
    input  logic [9:0]        rast_width,
    input  logic [8:0]        rast_height,
    input  logic [2:0]        rast_color_input,
    input  logic              rast_done,
    input  logic              next_frame_switch,
    output logic              read_rast_pixel_rdy,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [2:0]        mem_wdata,
    output logic              write_bank,
    output logic              display_bank,
    output logic              frame_complete,
    output logic              frame_overrun,
    output logic [15:0]       drop_count
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = ADDR_W + 3;
    localparam logic [ADDR_W-1:0]  c_H_RES = ADDR_W'(H_RES);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_ready;
    logic                 r_bank;
    logic                 r_frame_complete;
    logic                 r_frame_overrun;
    logic [15:0]          r_drop_count;

    logic [c_ENT_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [ADDR_W-1:0]    w_offset;
    logic [c_ENT_W-1:0]   w_head;

    // A handshake completes only while ready is up, which is only in ACCEPT.
    assign w_accept   = rast_pixel_rdy & r_ready;
    assign w_in_range = (32'(rast_width) < 32'(H_RES)) && (32'(rast_height) < 32'(V_RES));
    assign w_push     = w_accept & w_in_range;
    assign w_empty    = (r_count == '0);
    // Scan-out has priority: the head is only written when memory is free.
    assign w_pop      = ~w_empty & ~mem_busy;
    assign w_offset   = ADDR_W'(rast_height) * c_H_RES + ADDR_W'(rast_width);
    assign w_head     = r_fifo[r_rd_ptr];

    // FIFO occupancy after this edge, shared by the ready and drain decisions.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    // Pixel FIFO storage and pointers; cleared on reset so no stale write survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {w_offset, rast_color_input};
                r_wr_ptr         <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Frame control FSM with registered ready, bank, pulses and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_ready          <= 1'b0;
            r_bank           <= 1'b0;
            r_frame_complete <= 1'b0;
            r_frame_overrun  <= 1'b0;
            r_drop_count     <= '0;
        end else begin
            r_frame_complete <= 1'b0;
            r_frame_overrun  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (next_frame_switch) begin
                        r_state <= S_ACCEPT;
                        r_ready <= (w_count_nxt != c_FULL);
                    end
                end
                S_ACCEPT: begin
                    if (w_accept && !w_in_range && (r_drop_count != 16'hFFFF)) begin
                        r_drop_count <= r_drop_count + 16'd1;
                    end
                    if (next_frame_switch) begin
                        r_frame_overrun <= 1'b1;
                    end
                    if (rast_done) begin
                        r_state <= S_DRAIN;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= (w_count_nxt != c_FULL);
                    end
                end
                S_DRAIN: begin
                    r_ready <= 1'b0;
                    if (next_frame_switch) begin
                        r_frame_overrun <= 1'b1;
                    end
                    // Complete once this edge leaves nothing left to write.
                    if (w_count_nxt == '0) begin
                        r_frame_complete <= 1'b1;
                        r_state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    if (next_frame_switch) begin
                        r_bank       <= ~r_bank;
                        r_drop_count <= '0;
                        r_state      <= S_ACCEPT;
                        r_ready      <= (w_count_nxt != c_FULL);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign read_rast_pixel_rdy = r_ready;
    assign mem_we              = w_pop;
    assign mem_addr            = {r_bank, w_head[c_ENT_W-1:3]};
    assign mem_wdata           = w_head[2:0];
    assign write_bank          = r_bank;
    assign display_bank        = ~r_bank;
    assign frame_complete      = r_frame_complete;
    assign frame_overrun       = r_frame_overrun;
    assign drop_count          = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_raster_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_pixel_sink
// Description : Directed self-checking bench for raster_pixel_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_pixel_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rast_pixel_rdy = 1'b0;
    logic [9:0]  rast_width = '0;
    logic [8:0]  rast_height = '0;
    logic [2:0]  rast_color_input = '0;
    logic        rast_done = 1'b0;
    logic        next_frame_switch = 1'b0;
    logic        mem_busy = 1'b0;
    logic        read_rast_pixel_rdy;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        write_bank;
    logic        display_bank;
    logic        frame_complete;
    logic        frame_overrun;
    logic [15:0] drop_count;

    raster_pixel_sink dut (
        .clk                 (clk),
        .rst                 (rst),
        .rast_pixel_rdy      (rast_pixel_rdy),
        .rast_width          (rast_width),
        .rast_height         (rast_height),
        .rast_color_input    (rast_color_input),
        .rast_done           (rast_done),
        .next_frame_switch   (next_frame_switch),
        .read_rast_pixel_rdy (read_rast_pixel_rdy),
        .mem_busy            (mem_busy),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .write_bank          (write_bank),
        .display_bank        (display_bank),
        .frame_complete      (frame_complete),
        .frame_overrun       (frame_overrun),
        .drop_count          (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  sx[$];
    logic [8:0]  sy[$];
    logic [2:0]  sc[$];
    logic [22:0] exp_q[$];
    int          busy_left = 0;
    int          n_acc  = 0;
    int          n_drop = 0;
    int          n_wr   = 0;
    logic        tb_bank = 1'b0;
    int          base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_px(input int x, input int y, input int c);
        sx.push_back(10'(x));
        sy.push_back(9'(y));
        sc.push_back(3'(c));
    endtask

    // One clock: present the next stimulus pixel, check any write, apply the edge.
    task automatic step();
        logic        hs;
        logic [22:0] e;
        logic [19:0] a;
        rast_pixel_rdy = (sx.size() > 0);
        if (sx.size() > 0) begin
            rast_width       = sx[0];
            rast_height      = sy[0];
            rast_color_input = sc[0];
        end
        mem_busy = (busy_left > 0);
        #1;
        if (mem_we === 1'b1) begin
            if (mem_busy) begin
                chk("we_while_busy", 32'(mem_we), 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[22:3]));
                chk("wr_data", 32'(mem_wdata), 32'(e[2:0]));
                n_wr++;
            end
        end
        hs = rast_pixel_rdy && read_rast_pixel_rdy;
        @(posedge clk);
        if (hs) begin
            if (sx[0] < 640 && sy[0] < 480) begin
                a = {tb_bank, 19'(sy[0] * 640 + sx[0])};
                exp_q.push_back({a, sc[0]});
            end else begin
                n_drop++;
            end
            n_acc++;
            void'(sx.pop_front());
            void'(sy.pop_front());
            void'(sc.pop_front());
        end
        if (busy_left > 0) busy_left--;
        #1;
        rast_pixel_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(read_rast_pixel_rdy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wbank", 32'(write_bank), 32'd0);
        chk("rst_dbank", 32'(display_bank), 32'd1);
        chk("rst_fc", 32'(frame_complete), 32'd0);
        chk("rst_fo", 32'(frame_overrun), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_ready", 32'(read_rast_pixel_rdy), 32'd0);

        // First frame start: no swap
        next_frame_switch = 1'b1;
        tick();
        next_frame_switch = 1'b0;
        chk("start_ready", 32'(read_rast_pixel_rdy), 32'd1);
        chk("start_wbank", 32'(write_bank), 32'd0);
        chk("start_fo", 32'(frame_overrun), 32'd0);

        // Single pixel (5,2,5) -> {0,1285}
        add_px(5, 2, 5);
        step();
        #1;
        chk("a_we", 32'(mem_we), 32'd1);
        chk("a_addr", 32'(mem_addr), 32'd1285);
        chk("a_wdata", 32'(mem_wdata), 32'd5);
        step();
        chk("a_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: 10 pixels while memory busy
        busy_left = 1000;
        base = n_acc;
        for (int i = 0; i < 10; i++) add_px(i, 3, i);
        repeat (12) step();
        chk("b_accepts_full", 32'(n_acc - base), 32'd8);
        chk("b_ready_full", 32'(read_rast_pixel_rdy), 32'd0);
        chk("b_we_busy", 32'(mem_we), 32'd0);
        busy_left = 0;
        base = n_wr;
        repeat (10) step();
        chk("b_writes", 32'(n_wr - base), 32'd10);
        chk("b_drained", 32'(exp_q.size()), 32'd0);
        chk("b_stim_done", 32'(sx.size()), 32'd0);

        // Out-of-range pixels
        base = n_drop;
        add_px(640, 0, 1);
        add_px(0, 480, 2);
        repeat (4) step();
        chk("c_handshakes", 32'(n_drop - base), 32'd2);
        chk("c_drop_count", 32'(drop_count), 32'd2);
        chk("c_no_write", 32'(exp_q.size()), 32'd0);

        // Overrun while accepting
        next_frame_switch = 1'b1;
        tick();
        next_frame_switch = 1'b0;
        chk("e_overrun", 32'(frame_overrun), 32'd1);
        chk("e_wbank", 32'(write_bank), 32'd0);
        chk("e_ready", 32'(read_rast_pixel_rdy), 32'd1);
        tick();
        chk("e_overrun_pulse", 32'(frame_overrun), 32'd0);
        add_px(1, 1, 3);
        repeat (3) step();
        chk("e_continue", 32'(exp_q.size()), 32'd0);

        // Last pixel with rast_done, memory busy 3 more cycles
        add_px(7, 4, 6);
        rast_done = 1'b1;
        busy_left = 4;
        step();
        rast_done = 1'b0;
        chk("d_ready_drain", 32'(read_rast_pixel_rdy), 32'd0);
        chk("d_kept", 32'(exp_q.size()), 32'd1);
        repeat (3) step();
        chk("d_fc_early", 32'(frame_complete), 32'd0);
        step();
        chk("d_fc", 32'(frame_complete), 32'd1);
        chk("d_written", 32'(exp_q.size()), 32'd0);
        tick();
        chk("d_fc_pulse", 32'(frame_complete), 32'd0);
        next_frame_switch = 1'b1;
        tick();
        next_frame_switch = 1'b0;
        tb_bank = 1'b1;
        chk("d_wbank", 32'(write_bank), 32'd1);
        chk("d_dbank", 32'(display_bank), 32'd0);
        chk("d_drop_clr", 32'(drop_count), 32'd0);
        chk("d_no_overrun", 32'(frame_overrun), 32'd0);
        chk("d_ready", 32'(read_rast_pixel_rdy), 32'd1);
        add_px(0, 0, 1);
        repeat (3) step();
        chk("d_bank1_write", 32'(exp_q.size()), 32'd0);

        // Reset with 4 entries queued
        busy_left = 1000;
        base = n_acc;
        for (int i = 0; i < 4; i++) add_px(10 + i, 5, i);
        repeat (4) step();
        chk("f_queued", 32'(n_acc - base), 32'd4);
        busy_left = 0;
        mem_busy = 1'b0;
        rst = 1'b0;
        #1;
        chk("f_we_rst", 32'(mem_we), 32'd0);
        chk("f_ready_rst", 32'(read_rast_pixel_rdy), 32'd0);
        chk("f_wbank_rst", 32'(write_bank), 32'd0);
        chk("f_dbank_rst", 32'(display_bank), 32'd1);
        exp_q.delete();
        tb_bank = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        base = n_wr;
        repeat (5) step();
        chk("f_idle_ready", 32'(read_rast_pixel_rdy), 32'd0);
        chk("f_no_stale", 32'(n_wr - base), 32'd0);
        chk("f_we_idle", 32'(mem_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
